// File: rtl/fifo2_ctrl.sv
// fifo2_ctrl: arbitrates two 1-bit producers and one consumer onto an external 4-deep fifo2.
// Latency: grants and fifo2 strobes are combinational; rd_valid/rd_data follow a pop by one cycle.
// Backpressure: writes are held off while full (unless a pop frees a slot); reads are held off while empty.
module fifo2_ctrl #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       wr_req,
  input  logic [1:0]       wr_data,
  input  logic             rd_req,
  input  logic             clr_req,
  input  logic             fifo_p,
  output logic             fifo_push,
  output logic             fifo_pop,
  output logic             fifo_clear,
  output logic             fifo_i,
  output logic [1:0]       wr_gnt,
  output logic             rd_gnt,
  output logic             rd_valid,
  output logic             rd_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             rr_q, rr_d;
  logic             rd_valid_q, rd_valid_d;

  logic             in_run;
  logic             flush;
  logic             pop_ok;
  logic             push_ok;
  logic             any_wr;
  logic             win;
  logic             push_en;

  // Decide which operations fifo2 may perform this cycle.
  // A flush (INIT or clr_req) suppresses every other operation.
  always_comb begin
    in_run  = (state_q == ST_RUN);
    flush   = ~in_run | clr_req;
    pop_ok  = ~flush & rd_req & (count_q != '0);
    // fifo2 pops before it pushes, so a full queue can still take a push alongside a pop.
    push_ok = ~flush & ((count_q < DEPTH_C) | pop_ok);
    any_wr  = |wr_req;
    // Producer 1 wins when it requests alone, or when both request and the pointer favours it.
    win     = wr_req[1] & (~wr_req[0] | rr_q);
    push_en = push_ok & any_wr;
  end

  // Drive the grant outputs and the fifo2 strobes.
  always_comb begin
    wr_gnt     = 2'b00;
    if (push_en) begin
      wr_gnt = win ? 2'b10 : 2'b01;
    end
    rd_gnt     = pop_ok;
    fifo_push  = push_en;
    fifo_pop   = pop_ok;
    fifo_clear = flush;
    fifo_i     = push_en & wr_data[win];
  end

  // Next-state values: FSM, occupancy, round-robin pointer and read-valid.
  always_comb begin
    state_d    = ST_RUN;
    rr_d       = rr_q;
    count_d    = count_q;
    rd_valid_d = pop_ok;
    if (push_en) begin
      // The pointer always moves past the last winner, contested or not.
      rr_d = ~win;
    end
    if (flush) begin
      count_d = '0;
    end else if (push_en && !pop_ok) begin
      count_d = count_q + ONE_C;
    end else if (pop_ok && !push_en) begin
      count_d = count_q - ONE_C;
    end
  end

  // State registers; reset lands in INIT so the first cycle flushes fifo2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_INIT;
      count_q    <= '0;
      rr_q       <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rr_q       <= rr_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Status outputs derived from the registered occupancy.
  always_comb begin
    count    = count_q;
    full     = (count_q == DEPTH_C);
    empty    = (count_q == '0);
    rd_valid = rd_valid_q;
    rd_data  = fifo_p;
  end

  // Safety properties on the strobes handed to fifo2.
  a_no_overflow : assert property (@(posedge clk) disable iff (reset)
    (fifo_push && !fifo_pop) |-> (count_q < DEPTH_C));
  a_no_underflow : assert property (@(posedge clk) disable iff (reset)
    fifo_pop |-> (count_q != '0));
  a_gnt_onehot : assert property (@(posedge clk) disable iff (reset)
    $onehot0(wr_gnt));
  a_clear_excl : assert property (@(posedge clk) disable iff (reset)
    fifo_clear |-> !(fifo_push || fifo_pop));
  a_count_range : assert property (@(posedge clk) disable iff (reset)
    count_q <= DEPTH_C);

endmodule

// File: tb/tb_fifo2_ctrl.sv
module tb_fifo2_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] wr_req = 2'b00;
  logic [1:0] wr_data = 2'b00;
  logic       rd_req = 1'b0;
  logic       clr_req = 1'b0;
  logic       fifo_p;
  logic       fifo_push, fifo_pop, fifo_clear, fifo_i;
  logic [1:0] wr_gnt;
  logic       rd_gnt, rd_valid, rd_data;
  logic [2:0] count;
  logic       full, empty;

  int n_tests = 0;
  int n_fail  = 0;

  fifo2_ctrl #(.DEPTH(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .wr_req(wr_req), .wr_data(wr_data),
    .rd_req(rd_req), .clr_req(clr_req), .fifo_p(fifo_p),
    .fifo_push(fifo_push), .fifo_pop(fifo_pop), .fifo_clear(fifo_clear),
    .fifo_i(fifo_i), .wr_gnt(wr_gnt), .rd_gnt(rd_gnt), .rd_valid(rd_valid),
    .rd_data(rd_data), .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  // Behavioural fifo2: no reset, starts with junk, P is loaded by a pop, pop happens before push.
  bit   env_q[$] = '{1'b1, 1'b0, 1'b1};
  logic env_p = 1'b0;
  assign fifo_p = env_p;
  always @(posedge clk) begin
    if (fifo_clear) begin
      env_q.delete();
    end else begin
      if (fifo_pop && env_q.size() > 0) env_p <= env_q.pop_front();
      if (fifo_push) env_q.push_back(fifo_i);
    end
  end

  // Reference model of the controller.
  bit m_q[$];
  bit exp_rd[$];
  bit m_rr = 1'b0;
  bit m_init = 1'b1;
  bit m_last_pop = 1'b0;
  logic [1:0] g_wr;
  logic g_rd;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Read-data monitor: every rd_valid must carry the oldest outstanding popped bit.
  bit e_mon;
  always @(negedge clk) begin
    if (!reset && rd_valid) begin
      if (exp_rd.size() == 0) begin
        chk("rd_valid_unexpected", 1, 0);
      end else begin
        e_mon = exp_rd.pop_front();
        chk("rd_data", rd_data, e_mon);
      end
    end
  end

  // One clock cycle: apply inputs just after the edge, check at the falling edge, update the model.
  task automatic step(input logic [1:0] wq, input logic [1:0] wd, input logic rq, input logic cq);
    bit e_clear, e_pop, e_push, e_win, e_i;
    int cnt;
    wr_req = wq; wr_data = wd; rd_req = rq; clr_req = cq;
    @(negedge clk);
    cnt = m_q.size();
    e_clear = m_init || cq;
    e_pop = 0; e_push = 0; e_win = 0; e_i = 0;
    if (!e_clear) begin
      e_pop = rq && (cnt > 0);
      if ((cnt < 4 || e_pop) && wq != 2'b00) begin
        e_push = 1;
        e_win  = (wq == 2'b11) ? m_rr : (wq == 2'b10);
        e_i    = wd[e_win];
      end
    end
    chk("count", count, cnt);
    chk("full", full, cnt == 4);
    chk("empty", empty, cnt == 0);
    chk("rd_valid", rd_valid, m_last_pop);
    chk("wr_gnt", wr_gnt, e_push ? (e_win ? 2 : 1) : 0);
    chk("rd_gnt", rd_gnt, e_pop);
    chk("fifo_push", fifo_push, e_push);
    chk("fifo_pop", fifo_pop, e_pop);
    chk("fifo_clear", fifo_clear, e_clear);
    chk("fifo_i", fifo_i, e_i);
    if (e_clear) begin
      m_q.delete();
    end else begin
      if (e_pop) exp_rd.push_back(m_q.pop_front());
      if (e_push) begin
        m_q.push_back(e_i);
        m_rr = !e_win;
      end
    end
    g_wr = e_push ? (e_win ? 2'b10 : 2'b01) : 2'b00;
    g_rd = e_pop;
    m_last_pop = e_pop;
    m_init = 0;
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse starting mid-cycle; checks the immediate effect, then releases.
  task automatic do_reset();
    #1 reset = 1'b1;
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_wr_gnt", wr_gnt, 0);
    chk("rst_rd_gnt", rd_gnt, 0);
    chk("rst_fifo_push", fifo_push, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    m_q.delete();
    exp_rd.delete();
    m_rr = 0;
    m_init = 1;
    m_last_pop = 0;
  endtask

  logic [1:0] pw, pd;
  logic       pr;
  logic [3:0] bits4;

  initial begin
    @(posedge clk);
    #1;
    do_reset();
    step(2'b00, 2'b00, 0, 0);            // INIT cycle
    step(2'b00, 2'b00, 0, 0);            // first RUN cycle

    // Producer 0 writes 1,0,1,1 then a fifth attempt while full; then four reads.
    bits4 = 4'b1101;
    for (int k = 0; k < 5; k++) step(2'b01, {1'b0, bits4[k % 4]}, 0, 0);
    for (int k = 0; k < 4; k++) step(2'b00, 2'b00, 1, 0);
    step(2'b00, 2'b00, 0, 0);

    // Both producers and the consumer active from a fresh reset.
    do_reset();
    step(2'b11, 2'b10, 1, 0);            // INIT: nothing granted
    for (int k = 0; k < 6; k++) step(2'b11, 2'b10, 1, 0);
    step(2'b00, 2'b00, 1, 0);
    step(2'b00, 2'b00, 0, 0);

    // Full queue, producer 1 and consumer together.
    for (int k = 0; k < 4; k++) step(2'b01, {1'b0, 1'($urandom_range(0, 1))}, 0, 0);
    step(2'b10, 2'b10, 1, 0);
    for (int k = 0; k < 4; k++) step(2'b00, 2'b00, 1, 0);
    step(2'b00, 2'b00, 0, 0);

    // Flush at count 3 overriding every request.
    for (int k = 0; k < 3; k++) step(2'b10, 2'b10, 0, 0);
    step(2'b11, 2'b11, 1, 1);
    step(2'b00, 2'b00, 0, 0);

    // Reset mid-burst at count 2, then a read with nothing queued.
    step(2'b01, 2'b01, 0, 0);
    step(2'b01, 2'b00, 0, 0);
    do_reset();
    step(2'b00, 2'b00, 0, 0);            // INIT
    step(2'b00, 2'b00, 1, 0);            // refused: empty
    step(2'b10, 2'b10, 1, 0);            // write granted, read still refused
    step(2'b00, 2'b00, 1, 0);
    step(2'b00, 2'b00, 0, 0);

    // Randomized traffic obeying the hold-until-granted protocol.
    pw = 2'b00; pd = 2'b00; pr = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pw[i] && $urandom_range(0, 2) != 0) begin
          pw[i] = 1'b1;
          pd[i] = 1'($urandom_range(0, 1));
        end
      end
      if (!pr && $urandom_range(0, 1) == 1) pr = 1'b1;
      if (c == 500 || c == 1100) begin
        do_reset();
      end
      step(pw, pd, pr, $urandom_range(0, 39) == 0);
      for (int i = 0; i < 2; i++) if (g_wr[i]) pw[i] = 1'b0;
      if (g_rd) pr = 1'b0;
    end

    // Drain whatever remains and confirm every popped bit was presented.
    for (int k = 0; k < 6; k++) step(2'b00, 2'b00, 1, 0);
    step(2'b00, 2'b00, 0, 0);
    chk("rd_outstanding", exp_rd.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo2_ctrl.md
Name: fifo2_ctrl

Overview:
- Controller that shares the 4-deep, 1-bit `fifo2` queue between two bit producers and one consumer.
- Generates `fifo2`'s push/pop/clear/I strobes and arbitrates the producers round-robin.
- Tracks occupancy so that `fifo2` is never pushed when full or popped when empty.
- Sits directly beside the `fifo2` instance; all strobe outputs wire 1:1 to `fifo2` inputs on the same `clk`.

Parameters:
- DEPTH, 4, capacity of the attached queue; must equal the `fifo2` depth.
- CNT_W, 3, width of the occupancy counter; must hold 0..DEPTH.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- wr_req  input  2  per-producer push request; held high until granted.
- wr_data  input  2  per-producer data bit; wr_data[i] belongs to wr_req[i].
- rd_req  input  1  consumer pop request; held until rd_gnt.
- clr_req  input  1  synchronous flush request.
- fifo_p  input  1  `P` output of `fifo2`.
- fifo_push  output  1  to `fifo2` push.
- fifo_pop  output  1  to `fifo2` pop.
- fifo_clear  output  1  to `fifo2` clear.
- fifo_i  output  1  to `fifo2` I.
- wr_gnt  output  2  one-hot write grant, combinational, same cycle as the push.
- rd_gnt  output  1  read grant, combinational, same cycle as the pop.
- rd_valid  output  1  registered; high the cycle after a granted pop.
- rd_data  output  1  equals fifo_p; meaningful when rd_valid=1.
- count  output  CNT_W  registered occupancy.
- full  output  1  count==DEPTH.
- empty  output  1  count==0.

Behaviour:

State machine:
- Two states: INIT and RUN.
- Reset asserted: state=INIT, count=0, rr_ptr=0, rd_valid=0. Takes effect immediately (async).
- INIT lasts exactly one clk cycle after reset deasserts.
  - fifo_clear=1; fifo_push=0; fifo_pop=0.
  - All grants are 0.
  - Then RUN.
- `fifo2` has no reset of its own; INIT is what empties it.
- Reset mid-operation: any push/pop in flight is abandoned; the queue is re-flushed in INIT.

RUN, clr_req=1:
- fifo_clear=1; fifo_push=0; fifo_pop=0.
- wr_gnt=0; rd_gnt=0.
- Next count=0; next rd_valid=0.
- clr_req overrides any simultaneous wr_req/rd_req.

RUN, clr_req=0, read:
- pop_ok = rd_req & (count!=0).
- rd_gnt=pop_ok; fifo_pop=pop_ok.

RUN, clr_req=0, write:
- push_ok = (count<DEPTH) | pop_ok. The full+pop+push case is legal because `fifo2` pops before pushing.
- Only one wr_req high: that requester is granted when push_ok.
- Both high: grant requester rr_ptr.
- On a granted write when both were requesting: rr_ptr <= ~granted index.
- On a granted write with a single requester: rr_ptr <= ~granted index (the pointer always moves past the last winner).
- No grant: rr_ptr unchanged.
- fifo_push = |wr_gnt.
- fifo_i = wr_data[granted index], or 0 when no grant.

Occupancy update:
- count += fifo_push - fifo_pop at the rising edge.
- Simultaneous push and pop: count unchanged.
- count never wraps past DEPTH or below 0.

Read data timing:
- rd_valid <= pop_ok.
- rd_data = fifo_p.
- A bit granted in cycle N is presented on rd_data with rd_valid=1 in cycle N+1.

Empty/full conditions:
- Empty with simultaneous rd_req and wr_req: pop is refused, push is granted, count 0->1. Popping an empty `fifo2` together with a push is illegal in `fifo2`.
- Full with wr_req and no rd_req: wr_gnt=0; the request stays pending with no data loss.

Ordering and fairness:
- Queue order is the grant order.
- Requester i's data is accepted only in the cycle wr_gnt[i]=1.

Test Plan:
- Reset pulse, then idle: during reset count=0, empty=1, grants 0. Cycle 1 after release has fifo_clear=1. Cycle 2 is in RUN with fifo_clear=0.
- Producer 0 writes 1,0,1,1 on consecutive cycles, 5th write attempted: four wr_gnt[0] pulses, count 1..4, full=1. Fifth attempt has wr_gnt=0 and count stays 4. Then 4 rd_req produce rd_data 1,0,1,1, each with rd_valid=1 one cycle after rd_gnt; count ends at 0 with empty=1.
- Both producers request continuously, wr_data=2'b10, count=0, rd_req=1 every cycle: grants alternate 01,10,01,…. The first pop is refused because the queue is empty. count settles 1 and stays 1. rd_data sequence is 0,1,0,1.
- Full (count=4), wr_req[1]=1 with rd_req=1 in the same cycle: rd_gnt=1 and wr_gnt[1]=1. count stays 4. Oldest bit appears on rd_data next cycle; the new bit is last in order.
- count=3, clr_req=1 together with wr_req=2'b11 and rd_req=1: fifo_clear=1, all grants 0, fifo_push=fifo_pop=0. Next count=0, empty=1, rd_valid=0.
- Reset asserted asynchronously mid-burst (count=2): count=0 immediately, before the next clk edge. INIT cycle follows release. A subsequent rd_req gets no grant until a write occurs.
